// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue stage: operand width, function codes, flag bit
// positions, the idle function code and the issue FSM state encoding.
package alu_pkg;

  localparam int ALU_W = 16;

  localparam logic [3:0] FN_ADD   = 4'b0000;
  localparam logic [3:0] FN_SUB   = 4'b0001;
  localparam logic [3:0] FN_MUL   = 4'b0010;
  localparam logic [3:0] FN_DIV   = 4'b0011;
  localparam logic [3:0] FN_MOD   = 4'b0100;
  localparam logic [3:0] FN_AND   = 4'b0101;
  localparam logic [3:0] FN_OR    = 4'b0110;
  localparam logic [3:0] FN_XOR   = 4'b0111;
  localparam logic [3:0] FN_NOT   = 4'b1000;
  localparam logic [3:0] FN_CMPEQ = 4'b1001;
  localparam logic [3:0] FN_CMPLT = 4'b1010;
  localparam logic [3:0] FN_CMPGT = 4'b1011;
  localparam logic [3:0] FN_SHL   = 4'b1100;
  localparam logic [3:0] FN_SHR   = 4'b1101;

  // The ALU decodes this code to a zero result with no class flag set.
  localparam logic [3:0] IDLE_FUNC = 4'b1111;

  localparam int FLAG_ARITH = 3;
  localparam int FLAG_LOGIC = 2;
  localparam int FLAG_CMP   = 1;
  localparam int FLAG_SHIFT = 0;

  localparam logic [3:0] DIV0_FLAGS = 4'b1000;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DRIVE = 2'd1;
  localparam state_t ST_RESP  = 2'd2;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command and result valid/ready bundle between a command producer and alu_issue_ctrl.
interface alu_issue_ctrl_if #(parameter int W = alu_pkg::ALU_W);

  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_func;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic [3:0]   res_flags;
  logic         res_err;

  modport master (
    output cmd_valid, cmd_func, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data, res_flags, res_err
  );

  modport slave (
    input  cmd_valid, cmd_func, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data, res_flags, res_err
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Command FIFO, DEPTH x DW, pointers wrap modulo DEPTH; the head entry is visible
// combinationally so the issue FSM can register it on the pop edge.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 36
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en_i,
  input  logic [DW-1:0]          wr_data_i,
  input  logic                   rd_en_i,
  output logic [DW-1:0]          rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_wr;
  logic          do_rd;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_wr   = wr_en_i & ~full_o;
  assign do_rd   = rd_en_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue stage: buffers {func,a,b}, drives one command at a time, waits ALU_LAT edges
// and captures the result. Optional zero-operand divide suppression: DIV0_CHECK_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int W       = ALU_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_issue_ctrl_if.slave        io,
  output logic [W-1:0]           alu_a,
  output logic [W-1:0]           alu_b,
  output logic [3:0]             alu_func,
  input  logic [W-1:0]           alu_out,
  input  logic [3:0]             alu_flags,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int DW = 4 + 2*W;
  localparam int CW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          issue;
  logic [DW-1:0] head;
  logic [3:0]    head_func;
  logic [W-1:0]  head_a;
  logic [W-1:0]  head_b;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  alu_a_q, alu_a_d;
  logic [W-1:0]  alu_b_q, alu_b_d;
  logic [3:0]    alu_func_q, alu_func_d;
  logic          res_valid_q, res_valid_d;
  logic [W-1:0]  res_data_q, res_data_d;
  logic [3:0]    res_flags_q, res_flags_d;

  alu_cmd_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (io.cmd_valid),
    .wr_data_i ({io.cmd_func, io.cmd_a, io.cmd_b}),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign {head_func, head_a, head_b} = head;
  assign io.cmd_ready = ~fifo_full;

`ifdef DIV0_CHECK_EN
  logic res_err_q, res_err_d;
  logic head_div0;
  assign head_div0  = (head_func == FN_DIV) && ((head_a == '0) || (head_b == '0));
  assign io.res_err = res_err_q;
`else
  assign io.res_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_func_d  = alu_func_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
`ifdef DIV0_CHECK_EN
    res_err_d   = res_err_q;
`endif
    pop   = 1'b0;
    issue = 1'b0;
    case (state_q)
      ST_IDLE: issue = ~fifo_empty;
      ST_DRIVE: begin
        if (cnt_q == CW'(ALU_LAT)) begin
          res_data_d  = alu_out;
          res_flags_d = alu_flags;
          res_valid_d = 1'b1;
`ifdef DIV0_CHECK_EN
          res_err_d   = 1'b0;
`endif
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        if (io.res_ready) begin
          if (!fifo_empty) begin
            issue = 1'b1;
          end else begin
            res_valid_d = 1'b0;
            alu_func_d  = IDLE_FUNC;
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A popped command either goes to the ALU or, if suppressed, straight to a result.
    if (issue) begin
      pop = 1'b1;
`ifdef DIV0_CHECK_EN
      if (head_div0) begin
        res_valid_d = 1'b1;
        res_data_d  = '1;
        res_flags_d = DIV0_FLAGS;
        res_err_d   = 1'b1;
        alu_func_d  = IDLE_FUNC;
        state_d     = ST_RESP;
      end else
`endif
      begin
        alu_a_d     = head_a;
        alu_b_d     = head_b;
        alu_func_d  = head_func;
        cnt_d       = '0;
        res_valid_d = 1'b0;
        state_d     = ST_DRIVE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_func_q  <= IDLE_FUNC;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_flags_q <= '0;
`ifdef DIV0_CHECK_EN
      res_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_func_q  <= alu_func_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
`ifdef DIV0_CHECK_EN
      res_err_q   <= res_err_d;
`endif
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_func     = alu_func_q;
  assign io.res_valid = res_valid_q;
  assign io.res_data  = res_data_q;
  assign io.res_flags = res_flags_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, result scoreboard, directed and random traffic.
module tb_alu_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int LAT   = 1;
  localparam int W     = 16;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  fl;
    logic        e;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_func, alu_flags;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;
  int n_res  = 0;

  res_t        exp_q[$];
  logic [15:0] log_d[$];
  logic [3:0]  log_f[$];
  logic        log_e[$];
  res_t        r;
  logic        stall_q = 1'b0;
  logic [15:0] held_d;
  logic [3:0]  held_f;
  logic        held_e;
  logic        seen_div = 1'b0;
  logic        rand_done = 1'b0;
  logic        burst_done = 1'b0;

  alu_issue_ctrl_if #(.W(W)) io ();

  alu_issue_ctrl #(.DEPTH(DEPTH), .ALU_LAT(LAT), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io         (io),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_func   (alu_func),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_calc(logic [3:0] f, logic [15:0] a, logic [15:0] b);
    case (f)
      4'd0:    return a + b;
      4'd1:    return b - a;
      4'd2:    return a * b;
      4'd3:    return (b == 0) ? 16'hFFFF : a / b;
      4'd4:    return (b == 0) ? 16'hFFFF : a % b;
      4'd5:    return a & b;
      4'd6:    return a | b;
      4'd7:    return a ^ b;
      4'd8:    return ~a;
      4'd9:    return {15'b0, a == b};
      4'd10:   return {15'b0, a < b};
      4'd11:   return {15'b0, a > b};
      4'd12:   return a << b[3:0];
      4'd13:   return a >> b[3:0];
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [3:0] ref_cls(logic [3:0] f);
    if (f <= 4'd4)  return 4'b1000;
    if (f <= 4'd8)  return 4'b0100;
    if (f <= 4'd11) return 4'b0010;
    if (f <= 4'd13) return 4'b0001;
    return 4'b0000;
  endfunction

  function automatic res_t ref_model(logic [3:0] f, logic [15:0] a, logic [15:0] b);
    res_t x;
`ifdef DIV0_CHECK_EN
    if (f == 4'd3 && (a == 0 || b == 0)) begin
      x.d = 16'hFFFF; x.fl = 4'b1000; x.e = 1'b1;
      return x;
    end
`endif
    x.d = ref_calc(f, a, b); x.fl = ref_cls(f); x.e = 1'b0;
    return x;
  endfunction

  // ALU stand-in: registered result, combinational class flags
  always @(posedge clk) alu_out <= ref_calc(alu_func, alu_a, alu_b);
  assign alu_flags = ref_cls(alu_func);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_alu_a"},    alu_a, 0);
    chk({tag, "_alu_b"},    alu_b, 0);
    chk({tag, "_alu_func"}, alu_func, 4'hF);
    chk({tag, "_res_valid"}, io.res_valid, 0);
    chk({tag, "_res_data"},  io.res_data, 0);
    chk({tag, "_res_flags"}, io.res_flags, 0);
    chk({tag, "_res_err"},   io.res_err, 0);
    chk({tag, "_level"},     fifo_level, 0);
    chk({tag, "_cmd_ready"}, io.cmd_ready, 1);
  endtask

  task automatic push(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    int  t;
    logic hs;
    t  = 0;
    hs = 1'b0;
    io.cmd_valid = 1'b1; io.cmd_func = f; io.cmd_a = a; io.cmd_b = b;
    do begin
      @(negedge clk);
      hs = io.cmd_ready;
      t++;
      @(posedge clk); #1;
    end while (!hs && t < 200);
    chk("push_accepted", hs, 1);
    io.cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || io.res_valid) && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // Scoreboard: handshakes are judged at the falling edge, ahead of the edge that takes them
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      chk("ready_vs_full", io.cmd_ready, fifo_level != 3'(DEPTH));
      if (stall_q) begin
        chk("hold_valid", io.res_valid, 1);
        chk("hold_data",  io.res_data, held_d);
        chk("hold_flags", io.res_flags, held_f);
        chk("hold_err",   io.res_err, held_e);
      end
      if (io.cmd_valid && io.cmd_ready)
        exp_q.push_back(ref_model(io.cmd_func, io.cmd_a, io.cmd_b));
      if (io.res_valid && io.res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", exp_q.size(), 1);
        end else begin
          r = exp_q.pop_front();
          chk("res_data",  io.res_data, r.d);
          chk("res_flags", io.res_flags, r.fl);
          chk("res_err",   io.res_err, r.e);
        end
        log_d.push_back(io.res_data);
        log_f.push_back(io.res_flags);
        log_e.push_back(io.res_err);
        $display("RES %0d data=%h flags=%b err=%b", n_res, io.res_data, io.res_flags, io.res_err);
        n_res++;
      end
      stall_q = io.res_valid && !io.res_ready;
      held_d  = io.res_data;
      held_f  = io.res_flags;
      held_e  = io.res_err;
      if (alu_func == 4'd3) seen_div = 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n0;
    io.cmd_valid = 1'b0; io.cmd_func = '0; io.cmd_a = '0; io.cmd_b = '0;
    io.res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst0");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single ADD: result 3 edges after the accept edge
    io.cmd_valid = 1'b1; io.cmd_func = 4'd0; io.cmd_a = 16'd5; io.cmd_b = 16'd7;
    @(posedge clk); #1;
    io.cmd_valid = 1'b0;
    k = 0;
    while (!io.res_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t1_latency", k, 3);
    chk("t1_data", io.res_data, 16'd12);
    chk("t1_flags", io.res_flags, 4'b1000);
    drain("t1");

    // back-to-back commands come out in order
    log_d.delete(); log_f.delete(); log_e.delete();
    push(4'd1, 16'd3, 16'd10);
    push(4'd5, 16'hF0F0, 16'h0FF0);
    push(4'd9, 16'd9, 16'd9);
    drain("t2");
    chk("t2_count", log_d.size(), 3);
    if (log_d.size() == 3) begin
      chk("t2_sub",   log_d[0], 16'd7);
      chk("t2_and",   log_d[1], 16'h00F0);
      chk("t2_cmpeq", log_d[2], 16'd1);
      chk("t2_f0", log_f[0], 4'b1000);
      chk("t2_f1", log_f[1], 4'b0100);
      chk("t2_f2", log_f[2], 4'b0010);
    end

    // back-pressure fills the FIFO; pop edge refuses the simultaneous push
    log_d.delete(); log_f.delete(); log_e.delete();
    io.res_ready = 1'b0;
    burst_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) push(4'd0, 16'(i * 10), 16'(i));
        burst_done = 1'b1;
      end
    join_none
    repeat (15) @(posedge clk);
    #1;
    chk("t3_ready_low", io.cmd_ready, 0);
    chk("t3_level", fifo_level, 4);
    chk("t3_accepted", exp_q.size(), 5);
    chk("t3_valid_held", io.res_valid, 1);
    io.res_ready = 1'b1;
    @(posedge clk); #1;
    chk("t6_level_after_pop", fifo_level, 3);
    k = 0;
    while (!burst_done && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t3_burst_done", burst_done, 1);
    drain("t3");
    chk("t3_count", log_d.size(), 6);
    if (log_d.size() == 6) chk("t3_last", log_d[5], 16'd55);

    // reset while the MUL is being driven discards it
    push(4'd2, 16'd300, 16'd200);
    k = 0;
    while (alu_func != 4'd2 && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t4_in_drive", alu_func, 4'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("t4");
    exp_q.delete();
    n0 = n_res;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t4_no_result", n_res, n0);
    chk("t4_valid_low", io.res_valid, 0);

    // divide with a zero operand
    log_d.delete(); log_f.delete(); log_e.delete();
    seen_div = 1'b0;
    push(4'd3, 16'd0, 16'd8);
    drain("t5");
    chk("t5_count", log_d.size(), 1);
    if (log_d.size() == 1) begin
`ifdef DIV0_CHECK_EN
      chk("t5_data", log_d[0], 16'hFFFF);
      chk("t5_err", log_e[0], 1);
      chk("t5_alu_untouched", seen_div, 0);
`else
      chk("t5_data", log_d[0], 16'h0000);
      chk("t5_err", log_e[0], 0);
      chk("t5_alu_driven", seen_div, 1);
`endif
    end

    // random traffic with random back-pressure
    n0 = n_res;
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          logic [3:0]  f;
          logic [15:0] a, b;
          f = ($urandom_range(0, 3) == 0) ? 4'd3 : 4'($urandom_range(0, 15));
          a = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
          b = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
          if ($urandom_range(0, 2) == 0) begin
            @(posedge clk); #1;
          end
          push(f, a, b);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          io.res_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        io.res_ready = 1'b1;
      end
    join
    drain("rand");
    chk("rand_count", n_res - n0, 80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
